cfs_md_tx_ctrl: RTL and testbench

Transmit-side MD master controller for the aligner. It pops aligned packets from the TX FIFO and drives them onto the MD TX interface under a valid/ready handshake. Along the way it legality-checks each entry, zero-masks the unused data bytes, and counts dropped entries and slave-reported errors. It sits between the TX FIFO pop port and the MD TX pins, and is the consumer of the packed entries the controller pushes.

---
 rtl/cfs_md_tx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cfs_md_tx_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfs_md_tx_ctrl.sv
// rtl/cfs_md_tx_ctrl.sv - MD TX master: pops FIFO entries, legality-checks, masks and transmits them
module cfs_md_tx_ctrl #(
  parameter int ALGN_DATA_WIDTH   = 32,
  parameter int CNT_WIDTH         = 8,
  parameter int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8),
  parameter int ALGN_SIZE_WIDTH   = $clog2(ALGN_DATA_WIDTH / 8) + 1,
  parameter int FIFO_WIDTH        = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pop_valid,
  input  logic [FIFO_WIDTH-1:0]        pop_data,
  output logic                         pop_ready,
  output logic                         md_tx_valid,
  output logic [ALGN_DATA_WIDTH-1:0]   md_tx_data,
  output logic [ALGN_OFFSET_WIDTH-1:0] md_tx_offset,
  output logic [ALGN_SIZE_WIDTH-1:0]   md_tx_size,
  input  logic                         md_tx_ready,
  input  logic                         md_tx_err,
  input  logic                         cnt_clr,
  output logic [CNT_WIDTH-1:0]         drop_cnt,
  output logic [CNT_WIDTH-1:0]         err_cnt,
  output logic                         irq_err
);

  localparam int BYTES = ALGN_DATA_WIDTH / 8;
  // One extra bit so offset+size can never wrap.
  localparam int SUM_W = ALGN_SIZE_WIDTH + 1;
  localparam logic [SUM_W-1:0]     BYTES_S = SUM_W'(BYTES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [ALGN_DATA_WIDTH-1:0]   in_data, in_data_masked;
  logic [ALGN_OFFSET_WIDTH-1:0] in_offset;
  logic [ALGN_SIZE_WIDTH-1:0]   in_size;
  logic [SUM_W-1:0]             in_end;
  logic                         in_legal, pop_fire, pop_keep, pop_drop;
  logic                         out_free, tx_err_hs;

  logic                         out_valid_q, out_valid_d;
  logic [ALGN_DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [ALGN_OFFSET_WIDTH-1:0] out_offset_q, out_offset_d;
  logic [ALGN_SIZE_WIDTH-1:0]   out_size_q, out_size_d;
  logic                         buf_valid_q, buf_valid_d;
  logic [ALGN_DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
  logic [ALGN_OFFSET_WIDTH-1:0] buf_offset_q, buf_offset_d;
  logic [ALGN_SIZE_WIDTH-1:0]   buf_size_q, buf_size_d;
  logic                         pop_ready_q;
  logic [CNT_WIDTH-1:0]         drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;
  logic                         irq_q;

  assign in_data   = pop_data[ALGN_DATA_WIDTH-1:0];
  assign in_offset = pop_data[ALGN_DATA_WIDTH +: ALGN_OFFSET_WIDTH];
  assign in_size   = pop_data[ALGN_DATA_WIDTH+ALGN_OFFSET_WIDTH +: ALGN_SIZE_WIDTH];
  assign in_end    = SUM_W'(in_offset) + SUM_W'(in_size);
  assign in_legal  = (in_size != '0) && (in_end <= BYTES_S);

  assign pop_fire  = pop_valid & pop_ready_q;
  assign pop_keep  = pop_fire & in_legal;
  assign pop_drop  = pop_fire & ~in_legal;
  assign out_free  = ~out_valid_q | md_tx_ready;
  assign tx_err_hs = out_valid_q & md_tx_ready & md_tx_err;

  // Zero every byte lane outside [offset, offset+size) before the entry is stored
  always_comb begin
    in_data_masked = '0;
    for (int b = 0; b < BYTES; b++) begin
      if ((SUM_W'(b) >= SUM_W'(in_offset)) && (SUM_W'(b) < in_end)) begin
        in_data_masked[8*b +: 8] = in_data[8*b +: 8];
      end
    end
  end

  // Next state of OUT/BUF: drain BUF first, else bypass the pop, else park the pop in BUF
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_offset_d = out_offset_q;
    out_size_d   = out_size_q;
    buf_valid_d  = buf_valid_q;
    buf_data_d   = buf_data_q;
    buf_offset_d = buf_offset_q;
    buf_size_d   = buf_size_q;
    if (out_free && buf_valid_q) begin
      out_valid_d  = 1'b1;
      out_data_d   = buf_data_q;
      out_offset_d = buf_offset_q;
      out_size_d   = buf_size_q;
      buf_valid_d  = pop_keep;
      if (pop_keep) begin
        buf_data_d   = in_data_masked;
        buf_offset_d = in_offset;
        buf_size_d   = in_size;
      end
    end else if (out_free && pop_keep) begin
      out_valid_d  = 1'b1;
      out_data_d   = in_data_masked;
      out_offset_d = in_offset;
      out_size_d   = in_size;
    end else if (out_free) begin
      out_valid_d  = 1'b0;
    end else if (pop_keep) begin
      buf_valid_d  = 1'b1;
      buf_data_d   = in_data_masked;
      buf_offset_d = in_offset;
      buf_size_d   = in_size;
    end
  end

  // Saturating status counters; a clear overrides a same-cycle increment
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (cnt_clr) begin
      drop_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      if (pop_drop && (drop_cnt_q != CNT_MAX)) drop_cnt_d = drop_cnt_q + 1'b1;
      if (tx_err_hs && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State registers; pop_ready is registered so it stays low through reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_offset_q <= '0;
      out_size_q   <= '0;
      buf_valid_q  <= 1'b0;
      buf_data_q   <= '0;
      buf_offset_q <= '0;
      buf_size_q   <= '0;
      pop_ready_q  <= 1'b0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_offset_q <= out_offset_d;
      out_size_q   <= out_size_d;
      buf_valid_q  <= buf_valid_d;
      buf_data_q   <= buf_data_d;
      buf_offset_q <= buf_offset_d;
      buf_size_q   <= buf_size_d;
      pop_ready_q  <= ~buf_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      err_cnt_q    <= err_cnt_d;
      irq_q        <= tx_err_hs;
    end
  end

  assign pop_ready    = pop_ready_q;
  assign md_tx_valid  = out_valid_q;
  assign md_tx_data   = out_data_q;
  assign md_tx_offset = out_offset_q;
  assign md_tx_size   = out_size_q;
  assign drop_cnt     = drop_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign irq_err      = irq_q;

endmodule

// File: tb/tb_cfs_md_tx_ctrl.sv
// tb/tb_cfs_md_tx_ctrl.sv - randomized self-checking bench for cfs_md_tx_ctrl against a queue model
module tb_cfs_md_tx_ctrl;
  localparam int DW = 32;
  localparam int OW = 2;
  localparam int SW = 3;
  localparam int FW = DW + OW + SW;
  localparam int BYTES = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pop_valid = 1'b0;
  logic [FW-1:0] pop_data = '0;
  logic          md_tx_ready = 1'b0;
  logic          md_tx_err = 1'b0;
  logic          cnt_clr = 1'b0;

  logic          pop_ready, md_tx_valid, irq_err;
  logic [DW-1:0] md_tx_data;
  logic [OW-1:0] md_tx_offset;
  logic [SW-1:0] md_tx_size;
  logic [7:0]    drop_cnt, err_cnt;

  logic          pop_ready2, md_tx_valid2, irq_err2;
  logic [DW-1:0] md_tx_data2;
  logic [OW-1:0] md_tx_offset2;
  logic [SW-1:0] md_tx_size2;
  logic [1:0]    drop_cnt2, err_cnt2;

  always #5 clk = ~clk;

  cfs_md_tx_ctrl #(.ALGN_DATA_WIDTH(32), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .md_tx_valid(md_tx_valid), .md_tx_data(md_tx_data), .md_tx_offset(md_tx_offset),
    .md_tx_size(md_tx_size), .md_tx_ready(md_tx_ready), .md_tx_err(md_tx_err), .cnt_clr(cnt_clr),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt), .irq_err(irq_err)
  );

  cfs_md_tx_ctrl #(.ALGN_DATA_WIDTH(32), .CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .reset(reset), .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready2),
    .md_tx_valid(md_tx_valid2), .md_tx_data(md_tx_data2), .md_tx_offset(md_tx_offset2),
    .md_tx_size(md_tx_size2), .md_tx_ready(md_tx_ready), .md_tx_err(md_tx_err), .cnt_clr(cnt_clr),
    .drop_cnt(drop_cnt2), .err_cnt(err_cnt2), .irq_err(irq_err2)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the block is a FIFO of at most two masked packets.
  logic [FW-1:0] mq[$];
  logic [FW-1:0] src[$];
  bit            src_en = 1'b1;
  bit            rst_last = 1'b1;
  bit            irq_m = 1'b0;
  int            drop_m = 0, err_m = 0, drop2_m = 0, err2_m = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [FW-1:0] e);
    int sz;
    int of;
    sz = int'(e[36:34]);
    of = int'(e[33:32]);
    return (sz != 0) && (of + sz <= BYTES);
  endfunction

  function automatic logic [FW-1:0] mask_entry(input logic [FW-1:0] e);
    logic [63:0] m;
    int sz;
    int of;
    sz = int'(e[36:34]);
    of = int'(e[33:32]);
    m = ((64'd1 << (8 * sz)) - 64'd1) << (8 * of);
    return {e[36:32], e[31:0] & m[31:0]};
  endfunction

  function automatic int sat_inc(input int v, input int max, input bit inc, input bit clr);
    if (clr) return 0;
    if (inc && v < max) return v + 1;
    return v;
  endfunction

  function automatic logic [FW-1:0] rand_legal();
    int sz;
    int of;
    sz = $urandom_range(1, 4);
    of = $urandom_range(0, 4 - sz);
    return {3'(sz), 2'(of), 32'($urandom)};
  endfunction

  function automatic logic [FW-1:0] rand_any();
    return {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 32'($urandom)};
  endfunction

  task automatic step();
    bit            rdy;
    bit            hs;
    bit            ehs;
    logic [FW-1:0] e;
    bit            exp_rdy;
    pop_valid = src_en && (src.size() > 0);
    pop_data  = (src.size() > 0) ? src[0] : '0;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      rst_last = 1'b1;
      irq_m = 1'b0;
      drop_m = 0; err_m = 0; drop2_m = 0; err2_m = 0;
    end else begin
      rdy = !rst_last && (mq.size() < 2);
      hs  = (mq.size() > 0) && md_tx_ready;
      ehs = hs && md_tx_err;
      if (hs) void'(mq.pop_front());
      if (pop_valid && rdy) begin
        e = src.pop_front();
        if (is_legal(e)) begin
          mq.push_back(mask_entry(e));
        end else begin
          drop_m  = sat_inc(drop_m, 255, 1'b1, 1'b0);
          drop2_m = sat_inc(drop2_m, 3, 1'b1, 1'b0);
        end
      end
      if (cnt_clr) begin
        drop_m = 0;
        drop2_m = 0;
      end
      err_m  = sat_inc(err_m, 255, ehs, cnt_clr);
      err2_m = sat_inc(err2_m, 3, ehs, cnt_clr);
      irq_m = ehs;
      rst_last = 1'b0;
    end
    @(negedge clk);
    exp_rdy = !rst_last && (mq.size() < 2);
    check("pop_ready", 64'(pop_ready), 64'(exp_rdy));
    check("tx_valid", 64'(md_tx_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) check("tx_fields", 64'({md_tx_size, md_tx_offset, md_tx_data}), 64'(mq[0]));
    check("drop_cnt", 64'(drop_cnt), 64'(drop_m));
    check("err_cnt", 64'(err_cnt), 64'(err_m));
    check("irq_err", 64'(irq_err), 64'(irq_m));
    check("sat_pop_ready", 64'(pop_ready2), 64'(exp_rdy));
    check("sat_tx_valid", 64'(md_tx_valid2), 64'(mq.size() > 0));
    if (mq.size() > 0) check("sat_tx_fields", 64'({md_tx_size2, md_tx_offset2, md_tx_data2}), 64'(mq[0]));
    check("sat_drop_cnt", 64'(drop_cnt2), 64'(drop2_m));
    check("sat_err_cnt", 64'(err_cnt2), 64'(err2_m));
    check("sat_irq_err", 64'(irq_err2), 64'(irq_m));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(md_tx_valid), 64'd0);
    check({tag, "_data"}, 64'(md_tx_data), 64'd0);
    check({tag, "_offset"}, 64'(md_tx_offset), 64'd0);
    check({tag, "_size"}, 64'(md_tx_size), 64'd0);
    check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
    check({tag, "_err"}, 64'(err_cnt), 64'd0);
    check({tag, "_irq"}, 64'(irq_err), 64'd0);
    check({tag, "_ready"}, 64'(pop_ready), 64'd0);
  endtask

  initial begin
    // Reset state, then ready rises one cycle after deassertion
    reset = 1'b1;
    step(); step();
    check_all_zero("reset");
    reset = 1'b0;
    step();
    check("ready_after_reset", 64'(pop_ready), 64'd1);

    // Bypass path
    md_tx_ready = 1'b1;
    src.push_back({3'd2, 2'd1, 32'hAABBCCDD});
    step();
    check("bypass_data", 64'(md_tx_data), 64'h00BBCC00);
    check("bypass_offset", 64'(md_tx_offset), 64'd1);
    check("bypass_size", 64'(md_tx_size), 64'd2);
    step();
    check("bypass_done", 64'(md_tx_valid), 64'd0);

    // Back-pressure: two accepted, then ready falls; release drains in order
    md_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) src.push_back(rand_legal());
    for (int i = 0; i < 4; i++) step();
    check("bp_ready_low", 64'(pop_ready), 64'd0);
    md_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Illegal entries are dropped without occupying storage
    src.push_back({3'd0, 2'd1, 32'h11223344});
    src.push_back({3'd2, 2'd3, 32'h55667788});
    for (int i = 0; i < 3; i++) step();
    check("illegal_drop", 64'(drop_cnt), 64'd2);
    check("illegal_valid", 64'(md_tx_valid), 64'd0);
    check("illegal_ready", 64'(pop_ready), 64'd1);

    // Error handshakes, saturation of the narrow counter
    md_tx_err = 1'b1;
    for (int i = 0; i < 4; i++) src.push_back(rand_legal());
    for (int i = 0; i < 6; i++) step();
    check("err_four", 64'(err_cnt), 64'd4);
    for (int i = 0; i < 2; i++) src.push_back(rand_legal());
    for (int i = 0; i < 4; i++) step();
    check("err_six", 64'(err_cnt), 64'd6);
    check("err_sat", 64'(err_cnt2), 64'd3);

    // Error without handshake is ignored
    md_tx_ready = 1'b0;
    src.push_back(rand_legal());
    for (int i = 0; i < 3; i++) step();
    check("err_no_hs", 64'(err_cnt), 64'd6);

    // Clear wins over an increment; the irq pulse still fires
    md_tx_ready = 1'b1;
    cnt_clr = 1'b1;
    step();
    check("clr_err_cnt", 64'(err_cnt), 64'd0);
    check("clr_irq", 64'(irq_err), 64'd1);
    cnt_clr = 1'b0;
    md_tx_err = 1'b0;
    step();

    // Reset with OUT and BUF both full
    md_tx_ready = 1'b0;
    src.push_back(rand_legal());
    src.push_back(rand_legal());
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    check_all_zero("reset_stall");
    reset = 1'b0;
    step();
    md_tx_ready = 1'b1;
    step();
    check("post_reset_valid", 64'(md_tx_valid), 64'd0);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (src.size() < 3) src.push_back(($urandom_range(0, 4) == 0) ? rand_any() : rand_legal());
      src_en      = ($urandom_range(0, 3) != 0);
      md_tx_ready = ($urandom_range(0, 2) != 0);
      md_tx_err   = ($urandom_range(0, 3) == 0);
      cnt_clr     = ($urandom_range(0, 49) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
